// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared state type, init ROM and command helpers for lcd_ctrl
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EN_HI,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    localparam int LCD_INIT_LEN = 4;

    // Function set 8-bit/2-line, display on, clear, entry mode increment (index 0 first)
    localparam logic [LCD_INIT_LEN-1:0][7:0] LCD_INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear and return-home need the long execution wait; 0x03 is home with the don't-care bit set
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - request handshake bundle between the CPU register path and lcd_ctrl
interface lcd_ctrl_if;
    logic       valid;
    logic       ready;
    logic       rs;
    logic [7:0] data;

    modport master (output valid, output rs, output data, input ready);
    modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_req_fifo.sv
// rtl/lcd_req_fifo.sv - small request FIFO, only built when LCD_CTRL_FIFO_EN is defined
`ifdef LCD_CTRL_FIFO_EN
module lcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule
`endif

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 write sequencer with power-up init; LCD_CTRL_FIFO_EN adds a 4-deep request FIFO
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int EN_HI_CYC    = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    lcd_ctrl_if.slave  req,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o
);
    localparam int MAX_0   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_1   = (CMD_WAIT_CYC > EN_HI_CYC) ? CMD_WAIT_CYC : EN_HI_CYC;
    localparam int MAX_2   = (MAX_1 > SETUP_CYC) ? MAX_1 : SETUP_CYC;
    localparam int MAX_CYC = (MAX_0 > MAX_2) ? MAX_0 : MAX_2;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Reload values: a state lasting N cycles loads N-1 and leaves when the count hits 0
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN_HI = CNT_W'(EN_HI_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             en_q;
    logic             lcd_on_q;

    logic             src_valid;
    logic             src_rs;
    logic [7:0]       src_data;
    logic             take;

`ifdef LCD_CTRL_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [8:0] fifo_head;

    lcd_req_fifo #(.DEPTH(4), .WIDTH(9)) u_req_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (req.valid && req.ready),
        .push_data ({req.rs, req.data}),
        .pop       (take),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gated with lcd_on_q so every output reads 0 while reset is held
    assign req.ready             = lcd_on_q && !fifo_full;
    assign src_valid             = !fifo_empty;
    assign {src_rs, src_data}    = fifo_head;
    assign busy_o                = lcd_on_q && ((state_q != ST_IDLE) || !fifo_empty);
`else
    assign req.ready = (state_q == ST_IDLE) && done_q;
    assign src_valid = req.valid;
    assign src_rs    = req.rs;
    assign src_data  = req.data;
    assign busy_o    = lcd_on_q && (state_q != ST_IDLE);
`endif

    assign init_done_o = done_q;
    assign lcd_on_o    = lcd_on_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_data_o  = data_q;
    assign lcd_rw_o    = 1'b0;

    // State, counter, latched byte and EN strobe registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_PWRUP;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            idx_q    <= 2'd0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            lcd_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            en_q     <= (state_d == ST_EN_HI);
            lcd_on_q <= 1'b1;
        end
    end

    // Next-state sequencing: init ROM walk first, then one request per IDLE visit
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        rs_d    = rs_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = done_q;
        take    = 1'b0;
        case (state_q)
            ST_PWRUP: begin
                // First cycle after release arms the power-up delay
                if (!lcd_on_q) begin
                    cnt_d = LD_PWRUP;
                end else if (cnt_q == '0) begin
                    rs_d    = 1'b0;
                    data_d  = LCD_INIT_SEQ[0];
                    idx_d   = 2'd0;
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_HI;
                    cnt_d   = LD_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'(LCD_INIT_LEN - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = LCD_INIT_SEQ[idx_q + 2'd1];
                        state_d = ST_SETUP;
                        cnt_d   = LD_SETUP;
                    end
                end
            end
            ST_IDLE: begin
                if (done_q && src_valid) begin
                    take    = 1'b1;
                    rs_d    = src_rs;
                    data_d  = src_data;
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;
    localparam int PWRUP    = 100;
    localparam int SETUP    = 2;
    localparam int EN_HI    = 5;
    localparam int CMD_WAIT = 20;
    localparam int CLR_WAIT = 200;
`ifdef LCD_CTRL_FIFO_EN
    localparam int EN_LAT = 3;
`else
    localparam int EN_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done, busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    int         checks = 0;
    int         errors = 0;

    lcd_ctrl_if req_if ();

    lcd_ctrl #(
        .PWRUP_CYC    (PWRUP),
        .SETUP_CYC    (SETUP),
        .EN_HI_CYC    (EN_HI),
        .CMD_WAIT_CYC (CMD_WAIT),
        .CLR_WAIT_CYC (CLR_WAIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req         (req_if),
        .init_done_o (init_done),
        .busy_o      (busy),
        .lcd_on_o    (lcd_on),
        .lcd_en_o    (lcd_en),
        .lcd_rs_o    (lcd_rs),
        .lcd_rw_o    (lcd_rw),
        .lcd_data_o  (lcd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: observed timeout expected finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus watcher: RW low, no handshake before init, RS/DATA stable through setup and EN high
    logic       en_prev = 1'b0;
    logic       rs_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    int         stable = 0;
    always @(negedge clk) begin
        if ({lcd_rs, lcd_data} == {rs_prev, data_prev}) stable++;
        else stable = 0;
        if (rst_n) begin
            check("rw_low", lcd_rw, 1'b0);
`ifndef LCD_CTRL_FIFO_EN
            if (!init_done) check("no_ready_in_init", req_if.ready, 1'b0);
`endif
            if (lcd_en && en_prev) check("hold_during_en", {lcd_rs, lcd_data}, {rs_prev, data_prev});
            if (lcd_en && !en_prev) check("setup_before_en", stable >= SETUP, 1'b1);
        end
        en_prev   = lcd_en;
        rs_prev   = lcd_rs;
        data_prev = lcd_data;
    end

    // Starting from a negedge sample: count EN-low samples, then check byte and pulse width
    task automatic wait_pulse(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                              output int low);
        int width;
        low = 0;
        while (!lcd_en && low < 2000) begin
            low++;
            @(negedge clk);
        end
        check({tag, "_seen"}, lcd_en, 1'b1);
        if (lcd_en) begin
            check({tag, "_rs"}, lcd_rs, exp_rs);
            check({tag, "_data"}, lcd_data, exp_data);
            width = 0;
            while (lcd_en && width < 100) begin
                width++;
                @(negedge clk);
            end
            check({tag, "_width"}, width, EN_HI);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_init(input string tag);
        int low;
        wait_pulse({tag, "_38"}, 1'b0, 8'h38, low);
        wait_pulse({tag, "_0c"}, 1'b0, 8'h0C, low);
        check({tag, "_gap_38"}, low, CMD_WAIT + SETUP);
        wait_pulse({tag, "_01"}, 1'b0, 8'h01, low);
        check({tag, "_gap_0c"}, low, CMD_WAIT + SETUP);
        wait_pulse({tag, "_06"}, 1'b0, 8'h06, low);
        check({tag, "_gap_01"}, low, CLR_WAIT + SETUP);
        low = 0;
        while (!init_done && low < 100) begin
            low++;
            @(negedge clk);
        end
        check({tag, "_done_lat"}, low, CMD_WAIT);
    endtask

    initial begin
        int low;
        int r;
        req_if.valid = 1'b0;
        req_if.rs    = 1'b0;
        req_if.data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {lcd_en, lcd_rs, lcd_rw, lcd_on, init_done, req_if.ready, busy, lcd_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("lcd_on_after_release", lcd_on, 1'b1);
        check("busy_in_pwrup", busy, 1'b1);

        // Init sequence with no requests
        check_init("init1");
        check("ready_after_init", req_if.ready, 1'b1);
        check("idle_not_busy", busy, 1'b0);

        // Single data write 'A'
        req_if.valid = 1'b1;
        req_if.rs    = 1'b1;
        req_if.data  = 8'h41;
        @(negedge clk);
        req_if.valid = 1'b0;
`ifndef LCD_CTRL_FIFO_EN
        check("s2_ready_drop", req_if.ready, 1'b0);
`endif
        wait_pulse("s2", 1'b1, 8'h41, low);
        check("s2_en_lat", low, EN_LAT);
        wait_idle(r);
        check("s2_wait", r, CMD_WAIT);
        check("s2_ready_back", req_if.ready, 1'b1);

        // Clear followed back-to-back by set-DDRAM-address
        req_if.valid = 1'b1;
        req_if.rs    = 1'b0;
        req_if.data  = 8'h01;
        @(negedge clk);
        req_if.data  = 8'h80;
`ifdef LCD_CTRL_FIFO_EN
        @(negedge clk);
        req_if.valid = 1'b0;
`else
        check("s3_ready_drop", req_if.ready, 1'b0);
`endif
        wait_pulse("s3_clr", 1'b0, 8'h01, low);
        check("s3_clr_lat", low, 2);
`ifdef LCD_CTRL_FIFO_EN
        wait_pulse("s3_cmd", 1'b0, 8'h80, low);
        check("s3_cmd_gap", low, CLR_WAIT + 1 + SETUP);
`else
        wait_idle(r);
        check("s3_clr_wait", r, CLR_WAIT);
        check("s3_ready_after_clr", req_if.ready, 1'b1);
        @(negedge clk);
        req_if.valid = 1'b0;
        wait_pulse("s3_cmd", 1'b0, 8'h80, low);
        check("s3_cmd_lat", low, 2);
`endif
        wait_idle(r);
        check("s3_cmd_wait", r, CMD_WAIT);

        // Reset in the middle of an EN-high window
        req_if.valid = 1'b1;
        req_if.rs    = 1'b1;
        req_if.data  = 8'h7E;
        @(negedge clk);
        req_if.valid = 1'b0;
        r = 0;
        while (!lcd_en && r < 50) begin
            r++;
            @(negedge clk);
        end
        check("s5_en_seen", lcd_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5_rst_en", lcd_en, 1'b0);
        check("s5_rst_all", {lcd_en, lcd_rs, lcd_rw, lcd_on, init_done, req_if.ready, busy, lcd_data}, 0);

`ifdef LCD_CTRL_FIFO_EN
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_if.valid = 1'b1;
            req_if.rs    = 1'b1;
            req_if.data  = 8'(8'h31 + i);
            check($sformatf("s4_push%0d_ready", i), req_if.ready, (i < 4));
            @(negedge clk);
        end
        req_if.valid = 1'b0;
        check_init("init2");
        for (int i = 0; i < 4; i++) begin
            wait_pulse($sformatf("s4_pop%0d", i), 1'b1, 8'(8'h31 + i), low);
            check($sformatf("s4_pop%0d_gap", i), low, (i == 0) ? (1 + SETUP) : (CMD_WAIT + 1 + SETUP));
        end
        wait_idle(r);
        check("s4_drain_wait", r, CMD_WAIT);
`else
        // Request held valid from reset through the whole init sequence
        req_if.valid = 1'b1;
        req_if.rs    = 1'b1;
        req_if.data  = 8'h42;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_init("init2");
        check("s4_ready_at_done", req_if.ready, 1'b1);
        @(negedge clk);
        req_if.valid = 1'b0;
        check("s4_ready_drop", req_if.ready, 1'b0);
        wait_pulse("s4", 1'b1, 8'h42, low);
        check("s4_en_lat", low, 2);
        wait_idle(r);
        check("s4_wait", r, CMD_WAIT);
        r = 0;
        while (!lcd_en && r < 40) begin
            r++;
            @(negedge clk);
        end
        check("s4_single_accept", lcd_en, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
